// File: rtl/pll_reset_ce_gen_pkg.sv
// Shared types and helpers for the PLL reset / clock-enable generator.
package pll_rst_pkg;

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_WAIT  = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  localparam int CE_DIV_DEF    = 7;
  localparam int LOCK_WAIT_DEF = 1024;
  localparam int RST_HOLD_DEF  = 16;
  localparam int SYNC_STG_DEF  = 2;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pll_reset_ce_gen_sync_bit.sv
// Multi-flop synchroniser for one asynchronous level, cleared asynchronously.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= '0;
    else          sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_ce_gen.sv
// Holds the core in reset until PLL lock is stable, divides clk_sys into CPU clock enables
// and services OSD/user soft-reset flushes.
//
//   state   | meaning
//   S_HOLD  | no lock; core held in reset
//   S_WAIT  | lock seen; counting LOCK_WAIT stable cycles
//   S_RUN   | core running, ready=1
//   S_FLUSH | soft reset; core held for RST_HOLD ce_cpu periods
module pll_reset_ce_gen
  import pll_rst_pkg::*;
#(
  parameter int CE_DIV    = CE_DIV_DEF,
  parameter int LOCK_WAIT = LOCK_WAIT_DEF,
  parameter int RST_HOLD  = RST_HOLD_DEF,
  parameter int SYNC_STG  = SYNC_STG_DEF
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_reset,
  output logic       core_reset,
  output logic       ce_cpu,
  output logic       ce_cpu_n,
  output logic       ready,
  output logic [7:0] lock_lost
);

  localparam int CW = cnt_w(CE_DIV);
  localparam int WW = cnt_w(LOCK_WAIT);
  localparam int FW = cnt_w(RST_HOLD);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CE_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CE_DIV / 2 - 1);
  localparam logic [WW-1:0] WCNT_LAST = WW'(LOCK_WAIT - 1);
  localparam logic [FW-1:0] FCNT_LAST = FW'(RST_HOLD - 1);

  logic rst_int_n;
  logic lk;
  logic sr;

  sync_bit #(.STAGES(2)) u_rst_sync (
    .clk_i  (clk_sys),
    .rst_n_i(rst_n),
    .d_i    (1'b1),
    .q_o    (rst_int_n)
  );

  sync_bit #(.STAGES(SYNC_STG)) u_lk_sync (
    .clk_i  (clk_sys),
    .rst_n_i(rst_int_n),
    .d_i    (pll_locked),
    .q_o    (lk)
  );

  sync_bit #(.STAGES(SYNC_STG)) u_sr_sync (
    .clk_i  (clk_sys),
    .rst_n_i(rst_int_n),
    .d_i    (soft_reset),
    .q_o    (sr)
  );

  // Divider: enables are decoded from the next count so they line up with cnt_q.
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ce_q, cen_q;

  always_comb begin
    cnt_d = '0;
    if (lk) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_sys or negedge rst_int_n) begin
    if (!rst_int_n) begin
      cnt_q <= '0;
      ce_q  <= 1'b0;
      cen_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ce_q  <= lk && (cnt_d == CNT_LAST);
      cen_q <= lk && (cnt_d == CNT_HALF);
    end
  end

  state_t        state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [7:0]    lost_q, lost_d;
  logic          sr_q;
  logic          sr_rise;
  logic          core_reset_q, ready_q;

  assign sr_rise = sr && !sr_q;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    fcnt_d  = fcnt_q;
    lost_d  = lost_q;
    unique case (state_q)
      S_HOLD: begin
        wcnt_d = '0;
        if (lk) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!lk) begin
          state_d = S_HOLD;
          wcnt_d  = '0;
        end else if (wcnt_q == WCNT_LAST) begin
          if (ce_q) state_d = S_RUN;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!lk) begin
          state_d = S_HOLD;
          if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
        end else if (sr_rise) begin
          state_d = S_FLUSH;
          fcnt_d  = '0;
        end
      end
      S_FLUSH: begin
        if (!lk) begin
          state_d = S_HOLD;
        end else if (ce_q) begin
          if (fcnt_q == FCNT_LAST) begin
            if (!sr) state_d = S_RUN;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q      <= S_HOLD;
      wcnt_q       <= '0;
      fcnt_q       <= '0;
      lost_q       <= 8'd0;
      sr_q         <= 1'b0;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      fcnt_q       <= fcnt_d;
      lost_q       <= lost_d;
      sr_q         <= sr;
      core_reset_q <= (state_q != S_RUN);
      ready_q      <= (state_q == S_RUN);
    end
  end

  assign core_reset = core_reset_q;
  assign ready      = ready_q;
  assign ce_cpu     = ce_q;
  assign ce_cpu_n   = cen_q;
  assign lock_lost  = lost_q;

endmodule

// File: tb/tb_pll_reset_ce_gen.sv
// Randomised bench for pll_reset_ce_gen against a cycle-level behavioural reference.
module tb_pll_reset_ce_gen;

  localparam int CE_DIV    = 7;
  localparam int LOCK_WAIT = 100;
  localparam int RST_HOLD  = 16;
  localparam int SYNC_STG  = 2;

  localparam int M_HOLD  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_RUN   = 2;
  localparam int M_FLUSH = 3;

  logic       clk_sys    = 1'b0;
  logic       rst_n      = 1'b0;
  logic       pll_locked = 1'b1;
  logic       soft_reset = 1'b0;
  logic       core_reset, ce_cpu, ce_cpu_n, ready;
  logic [7:0] lock_lost;

  int checks   = 0;
  int failures = 0;

  pll_reset_ce_gen #(
    .CE_DIV   (CE_DIV),
    .LOCK_WAIT(LOCK_WAIT),
    .RST_HOLD (RST_HOLD),
    .SYNC_STG (SYNC_STG)
  ) dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .soft_reset(soft_reset),
    .core_reset(core_reset),
    .ce_cpu    (ce_cpu),
    .ce_cpu_n  (ce_cpu_n),
    .ready     (ready),
    .lock_lost (lock_lost)
  );

  always #4 clk_sys = ~clk_sys;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: edges since reset release, lock run length, ce pulses in a flush.
  int m_rel, m_run, m_fl, m_lost, m_mode;
  bit m_ce, m_cen, m_sr_last, exp_core, exp_ready;
  bit lk_pipe[SYNC_STG];
  bit sr_pipe[SYNC_STG];

  task automatic model_step();
    bit lk, sr, ce_before;
    int run_new;
    if (!rst_n) m_rel = 0;
    else if (m_rel < 3) m_rel++;
    if (m_rel < 3) begin
      m_run = 0; m_fl = 0; m_lost = 0; m_mode = M_HOLD;
      m_ce = 0; m_cen = 0; m_sr_last = 0; exp_core = 1; exp_ready = 0;
      for (int i = 0; i < SYNC_STG; i++) begin lk_pipe[i] = 0; sr_pipe[i] = 0; end
      return;
    end
    lk = lk_pipe[SYNC_STG-1];
    sr = sr_pipe[SYNC_STG-1];
    for (int i = SYNC_STG-1; i > 0; i--) begin
      lk_pipe[i] = lk_pipe[i-1];
      sr_pipe[i] = sr_pipe[i-1];
    end
    lk_pipe[0] = pll_locked;
    sr_pipe[0] = soft_reset;
    ce_before = m_ce;
    exp_core  = (m_mode != M_RUN);
    exp_ready = (m_mode == M_RUN);
    run_new   = lk ? m_run + 1 : 0;
    case (m_mode)
      M_HOLD:  if (lk) m_mode = M_WAIT;
      M_WAIT:  if (!lk) m_mode = M_HOLD;
               else if (run_new >= LOCK_WAIT + 1 && ce_before) m_mode = M_RUN;
      M_RUN:   if (!lk) begin
                 m_mode = M_HOLD;
                 if (m_lost < 255) m_lost++;
               end else if (sr && !m_sr_last) begin
                 m_mode = M_FLUSH;
                 m_fl = 0;
               end
      default: if (!lk) m_mode = M_HOLD;
               else if (ce_before) begin
                 m_fl++;
                 if (m_fl >= RST_HOLD && !sr) m_mode = M_RUN;
               end
    endcase
    m_run     = run_new;
    m_ce      = lk && (run_new % CE_DIV == CE_DIV - 1);
    m_cen     = lk && (run_new % CE_DIV == CE_DIV / 2 - 1);
    m_sr_last = sr;
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_step();
    #1;
    check_val("core_reset", int'(core_reset), int'(exp_core));
    check_val("ready", int'(ready), int'(exp_ready));
    check_val("ce_cpu", int'(ce_cpu), int'(m_ce));
    check_val("ce_cpu_n", int'(ce_cpu_n), int'(m_cen));
    check_val("lock_lost", int'(lock_lost), m_lost);
    check_val("ce_overlap", int'(ce_cpu & ce_cpu_n), 0);
  endtask

  task automatic wait_ready(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ready && n < limit);
    check_val("ready_reached", int'(ready), 1);
  endtask

  int n, last_ce, lost_before, rel_exp, len;

  initial begin
    // First multiple of CE_DIV past LOCK_WAIT+1 lock edges, plus 4 edges of
    // reset/input synchronisation and 1 edge of output register.
    rel_exp = ((LOCK_WAIT + 1 + CE_DIV - 1) / CE_DIV) * CE_DIV + 5;

    // 1: lock present from t0, release aligned to ce_cpu
    repeat (3) tick();
    check_val("reset_core", int'(core_reset), 1);
    check_val("reset_ready", int'(ready), 0);
    rst_n = 1'b1;
    wait_ready(LOCK_WAIT + 60, n);
    check_val("release_latency", n, rel_exp);

    // 2: divider cadence in S_RUN
    last_ce = -1;
    for (int t = 0; t < 80; t++) begin
      tick();
      if (ce_cpu) begin
        if (last_ce >= 0) check_val("ce_period", t - last_ce, CE_DIV);
        last_ce = t;
      end
      if (ce_cpu_n && last_ce >= 0) check_val("ce_n_offset", t - last_ce, CE_DIV / 2);
    end

    // 3: single-cycle lock glitch during S_WAIT restarts the wait
    pll_locked = 1'b0;
    repeat (4) tick();
    pll_locked = 1'b1;
    repeat ($urandom_range(10, 80)) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    wait_ready(LOCK_WAIT + 60, n);
    check_val("glitch_restart", int'(n >= LOCK_WAIT + SYNC_STG), 1);

    // 4: soft-reset pulses, including one held far past the flush length
    for (int k = 0; k < 6; k++) begin
      lost_before = int'(lock_lost);
      len = (k == 0) ? 3 : (k == 5) ? 300 : $urandom_range(1, 6);
      soft_reset = 1'b1;
      repeat (len) tick();
      soft_reset = 1'b0;
      wait_ready(RST_HOLD * CE_DIV + 40, n);
      check_val("flush_lost", int'(lock_lost), lost_before);
      repeat ($urandom_range(0, 10)) tick();
    end

    // 5: repeated lock loss saturates the counter; core_reset reacts promptly
    for (int k = 0; k < 300; k++) begin
      len = $urandom_range(1, 3);
      pll_locked = 1'b0;
      n = 0;
      do begin
        tick();
        n++;
        if (n == len) pll_locked = 1'b1;
      end while (!core_reset && n < 10);
      check_val("drop_react", n, SYNC_STG + 2);
      pll_locked = 1'b1;
      wait_ready(LOCK_WAIT + 60, n);
    end
    check_val("lost_saturated", int'(lock_lost), 255);

    // 6: asynchronous reset mid-flush
    soft_reset = 1'b1;
    repeat (20) tick();
    #1 rst_n = 1'b0;
    #1;
    check_val("async_core_reset", int'(core_reset), 1);
    check_val("async_ready", int'(ready), 0);
    check_val("async_ce", int'(ce_cpu), 0);
    check_val("async_ce_n", int'(ce_cpu_n), 0);
    check_val("async_lost", int'(lock_lost), 0);
    soft_reset = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    wait_ready(LOCK_WAIT + 60, n);
    check_val("relock_latency", n, rel_exp);

    // 7: random interleaving of lock loss and soft reset
    for (int t = 0; t < 4000; t++) begin
      if ($urandom_range(0, 299) == 0) pll_locked = ~pll_locked;
      else if (!pll_locked && $urandom_range(0, 9) == 0) pll_locked = 1'b1;
      if ($urandom_range(0, 39) == 0) soft_reset = ~soft_reset;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
